ctrl_seq: RTL and testbench
===========================

CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 Parameter IW, default 9, instruction width in bits.
REQ-002 Parameter OPW, default 4, opcode field width; opcode = Instruction[IW-1:IW-OPW], mode bit = Instruction[IW-OPW-1].
REQ-003 Parameter TO_W, default 4, memory-timeout counter width.
REQ-004 Parameter CW, default 16, retired-instruction counter width.
REQ-005 Clk  in  1  single clock; all state updates on rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 Start  in  1  begin or resume execution.
REQ-008 Instruction  in  IW  machine code from instruction ROM.
REQ-009 instr_valid  in  1  Instruction is valid this cycle.
REQ-010 ZERO  in  1  ALU flag: result is 0.
REQ-011 NEG  in  1  ALU flag: result is negative.
REQ-012 mem_ack  in  1  data memory completes the access.
REQ-013 Outputs, 1 bit each: pc_inc, jump_en, sc_en, sc_clr, reg_exe, imm_exe, mem_rd, mem_wr, mem_to_reg, reg_to_acc, acc_to_reg, assign_val, busy, done, mem_err.
REQ-014 instr_cnt  out  CW  count of retired instructions.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, EXEC, MEM, HALT.
REQ-016 IDLE: busy=0; Start=1 -> FETCH next cycle.
REQ-017 FETCH: busy=1; the block waits while instr_valid=0; instr_valid=1 latches Instruction into IR -> EXEC.
REQ-018 EXEC SHALL last exactly one cycle, with every control output decoded from IR only.
REQ-019 ADD/SUB/AND/OR: mode=0 -> reg_exe=1, mode=1 -> imm_exe=1; ADD/SUB also assert sc_en.
REQ-020 BEQ/BNE/BGE: reg_exe or imm_exe per mode; jump_en=1 when taken: BEQ on ZERO, BNE on !ZERO, BGE on !NEG.
REQ-021 JMP: jump_en=1. ASSIGN: assign_val=1. CLRSC: sc_clr=1.
REQ-022 MOV: mode=0 -> reg_to_acc=1, mode=1 -> acc_to_reg=1.
REQ-023 Non-memory EXEC: pc_inc = !jump_en; instr_cnt increments; -> FETCH.
REQ-024 LW/SW: EXEC -> MEM with no PC update.
REQ-025 MEM: mem_rd (LW) or mem_wr (SW) SHALL be held high each cycle until mem_ack.
REQ-026 MEM on mem_ack: LW asserts mem_to_reg that cycle; pc_inc=1; instr_cnt increments; -> FETCH.
REQ-027 MEM timeout counter: cleared on MEM entry, increments each cycle without ack; at 2^TO_W-1 without ack -> mem_err=1 (sticky), HALT.
REQ-028 mem_ack in the terminal-count cycle SHALL win over the timeout.
REQ-029 HALT opcode in EXEC -> HALT; instr_cnt increments; pc_inc=0.
REQ-030 HALT: done=1, busy=0; Start=1 -> FETCH with done cleared; mem_err is not cleared.
REQ-031 Undefined opcode: NOP (all strobes 0 except pc_inc=1); it retires.
REQ-032 Start in FETCH/EXEC/MEM SHALL be ignored.
REQ-033 instr_cnt SHALL wrap modulo 2^CW.
REQ-034 All strobes SHALL be 0 outside EXEC/MEM, and at most one of pc_inc/jump_en SHALL be high per cycle.

Reset
REQ-035 Reset SHALL force IDLE, IR=0, timeout=0, instr_cnt=0, and every output 0, in the cycle following assertion, from any state.
REQ-036 Reset SHALL take priority over Start, instr_valid and mem_ack; an access in progress is abandoned with no mem_to_reg.

Structure
REQ-037 Opcode enum in shared package definitions: ADD=0, SUB=1, AND=2, OR=3, BEQ=4, BNE=5, BGE=6, LW=7, SW=8, MOV=9, ASSIGN=A, CLRSC=B, JMP=C, HALT=F; the state enum also lives there.
REQ-038 Combinational decode SHALL be the sub-module ctrl_decode (IR + flags -> strobes), instantiated once; the FSM, IR, timeout counter and instr_cnt stay in ctrl_seq.

Verification (IW=9, TO_W=4)
REQ-039 Reset, Start, valid Instruction=0x013 (ADD imm) -> EXEC: imm_exe=1, sc_en=1, pc_inc=1; instr_cnt=1.
REQ-040 BEQ reg 0x080 with ZERO=1 -> jump_en=1, pc_inc=0; repeat with ZERO=0 -> jump_en=0, pc_inc=1.
REQ-041 LW 0x0E2 with mem_ack on the 3rd MEM cycle -> mem_rd high 3 cycles, mem_to_reg=1 on the ack cycle, then FETCH.
REQ-042 SW 0x100 with no ack -> mem_wr high 15 cycles, then mem_err=1, done=1; Start -> FETCH with mem_err still 1.
REQ-043 Reset asserted in MEM mid-access -> next cycle IDLE, all outputs 0, instr_cnt=0.
REQ-044 Execute 2^CW+1 NOPs (opcode D) -> instr_cnt=1 (wrap); Start pulses during the run have no effect.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// Shared opcode/state encodings and the strobe bundle exchanged between
// the sequencer and its combinational decoder.
package ctrl_seq_pkg;

  localparam int OP_BITS = 4;

  typedef enum logic [OP_BITS-1:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_AND    = 4'h2,
    OP_OR     = 4'h3,
    OP_BEQ    = 4'h4,
    OP_BNE    = 4'h5,
    OP_BGE    = 4'h6,
    OP_LW     = 4'h7,
    OP_SW     = 4'h8,
    OP_MOV    = 4'h9,
    OP_ASSIGN = 4'hA,
    OP_CLRSC  = 4'hB,
    OP_JMP    = 4'hC,
    OP_HALT   = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic pc_inc;
    logic jump_en;
    logic sc_en;
    logic sc_clr;
    logic reg_exe;
    logic imm_exe;
    logic mem_rd;
    logic mem_wr;
    logic mem_to_reg;
    logic reg_to_acc;
    logic acc_to_reg;
    logic assign_val;
  } strobes_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: opcode, mode bit and ALU flags to the
// EXEC-cycle strobes, plus classification used by the sequencer.
module ctrl_decode
  import ctrl_seq_pkg::*;
(
  input  opcode_t  op,
  input  logic     mode,
  input  logic     zero,
  input  logic     neg,
  output strobes_t strb,
  output logic     is_mem,
  output logic     is_load,
  output logic     is_halt
);

  always_comb begin
    strb    = '0;
    is_mem  = 1'b0;
    is_load = 1'b0;
    is_halt = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        strb.reg_exe = !mode;
        strb.imm_exe = mode;
        strb.sc_en   = 1'b1;
      end
      OP_AND, OP_OR: begin
        strb.reg_exe = !mode;
        strb.imm_exe = mode;
      end
      OP_BEQ: begin
        strb.reg_exe = !mode;
        strb.imm_exe = mode;
        strb.jump_en = zero;
      end
      OP_BNE: begin
        strb.reg_exe = !mode;
        strb.imm_exe = mode;
        strb.jump_en = !zero;
      end
      OP_BGE: begin
        strb.reg_exe = !mode;
        strb.imm_exe = mode;
        strb.jump_en = !neg;
      end
      OP_JMP:    strb.jump_en    = 1'b1;
      OP_ASSIGN: strb.assign_val = 1'b1;
      OP_CLRSC:  strb.sc_clr     = 1'b1;
      OP_MOV: begin
        strb.reg_to_acc = !mode;
        strb.acc_to_reg = mode;
      end
      OP_LW: begin
        is_mem  = 1'b1;
        is_load = 1'b1;
      end
      OP_SW:   is_mem  = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
    // Memory ops advance the PC only when the access completes.
    strb.pc_inc = !(strb.jump_en || is_mem || is_halt);
  end

endmodule

// File: rtl/ctrl_seq.sv
// Instruction sequencer: IDLE/FETCH/EXEC/MEM/HALT control with memory
// timeout, sticky error flag and retired-instruction counter.
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int IW   = 9,
  parameter int OPW  = 4,
  parameter int TO_W = 4,
  parameter int CW   = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [IW-1:0] Instruction,
  input  logic          instr_valid,
  input  logic          ZERO,
  input  logic          NEG,
  input  logic          mem_ack,
  output logic          pc_inc,
  output logic          jump_en,
  output logic          sc_en,
  output logic          sc_clr,
  output logic          reg_exe,
  output logic          imm_exe,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          mem_to_reg,
  output logic          reg_to_acc,
  output logic          acc_to_reg,
  output logic          assign_val,
  output logic          busy,
  output logic          done,
  output logic          mem_err,
  output logic [CW-1:0] instr_cnt
);

  // Last MEM-cycle count before giving up; reached on the (2^TO_W-1)th cycle.
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_t          state_reg, state_next;
  logic [IW-1:0]   ir_reg;
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic [CW-1:0]   instr_cnt_reg;
  logic            mem_err_reg;
  logic            retire;
  logic            err_set;
  strobes_t        strb;

  opcode_t  op;
  logic     mode;
  strobes_t dec_strb;
  logic     dec_is_mem, dec_is_load, dec_is_halt;
  logic     unused_operand;

  assign op             = opcode_t'(OP_BITS'(ir_reg[IW-1 -: OPW]));
  assign mode           = ir_reg[IW-OPW-1];
  assign unused_operand = ^ir_reg[IW-OPW-2:0];

  ctrl_decode u_decode (
    .op      (op),
    .mode    (mode),
    .zero    (ZERO),
    .neg     (NEG),
    .strb    (dec_strb),
    .is_mem  (dec_is_mem),
    .is_load (dec_is_load),
    .is_halt (dec_is_halt)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= ST_IDLE;
      ir_reg        <= '0;
      to_cnt_reg    <= '0;
      instr_cnt_reg <= '0;
      mem_err_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      to_cnt_reg <= to_cnt_next;
      if (state_reg == ST_FETCH && instr_valid) ir_reg <= Instruction;
      if (retire) instr_cnt_reg <= instr_cnt_reg + 1'b1;
      if (err_set) mem_err_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    to_cnt_next = to_cnt_reg;
    strb        = '0;
    retire      = 1'b0;
    err_set     = 1'b0;
    case (state_reg)
      ST_IDLE:  if (Start) state_next = ST_FETCH;
      ST_FETCH: if (instr_valid) state_next = ST_EXEC;
      ST_EXEC: begin
        strb        = dec_strb;
        to_cnt_next = '0;
        if (dec_is_mem) begin
          state_next = ST_MEM;
        end else begin
          retire     = 1'b1;
          state_next = dec_is_halt ? ST_HALT : ST_FETCH;
        end
      end
      ST_MEM: begin
        strb.mem_rd = dec_is_load;
        strb.mem_wr = !dec_is_load;
        // An ack in the terminal cycle completes the access normally.
        if (mem_ack) begin
          strb.mem_to_reg = dec_is_load;
          strb.pc_inc     = 1'b1;
          retire          = 1'b1;
          state_next      = ST_FETCH;
        end else if (to_cnt_reg == TO_LAST) begin
          err_set    = 1'b1;
          state_next = ST_HALT;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      ST_HALT:  if (Start) state_next = ST_FETCH;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign pc_inc     = strb.pc_inc;
  assign jump_en    = strb.jump_en;
  assign sc_en      = strb.sc_en;
  assign sc_clr     = strb.sc_clr;
  assign reg_exe    = strb.reg_exe;
  assign imm_exe    = strb.imm_exe;
  assign mem_rd     = strb.mem_rd;
  assign mem_wr     = strb.mem_wr;
  assign mem_to_reg = strb.mem_to_reg;
  assign reg_to_acc = strb.reg_to_acc;
  assign acc_to_reg = strb.acc_to_reg;
  assign assign_val = strb.assign_val;

  assign busy      = (state_reg == ST_FETCH) || (state_reg == ST_EXEC) || (state_reg == ST_MEM);
  assign done      = (state_reg == ST_HALT);
  assign mem_err   = mem_err_reg;
  assign instr_cnt = instr_cnt_reg;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: hand-computed output vectors checked with
// immediate assertions along one linear stimulus sequence.
module tb_ctrl_seq;

  localparam int CW = 8;

  // Output vector bit weights, MSB first:
  // pc_inc jump_en sc_en sc_clr reg_exe imm_exe mem_rd mem_wr
  // mem_to_reg reg_to_acc acc_to_reg assign_val busy done mem_err
  localparam logic [14:0] PC   = 15'h4000;
  localparam logic [14:0] JMP  = 15'h2000;
  localparam logic [14:0] SCEN = 15'h1000;
  localparam logic [14:0] SCCL = 15'h0800;
  localparam logic [14:0] REG  = 15'h0400;
  localparam logic [14:0] IMM  = 15'h0200;
  localparam logic [14:0] MRD  = 15'h0100;
  localparam logic [14:0] MWR  = 15'h0080;
  localparam logic [14:0] M2R  = 15'h0040;
  localparam logic [14:0] R2A  = 15'h0020;
  localparam logic [14:0] A2R  = 15'h0010;
  localparam logic [14:0] ASG  = 15'h0008;
  localparam logic [14:0] BUSY = 15'h0004;
  localparam logic [14:0] DONE = 15'h0002;
  localparam logic [14:0] ERR  = 15'h0001;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic [8:0]    Instruction = '0;
  logic          instr_valid = 1'b0;
  logic          ZERO = 1'b0;
  logic          NEG = 1'b0;
  logic          mem_ack = 1'b0;
  logic          pc_inc, jump_en, sc_en, sc_clr, reg_exe, imm_exe;
  logic          mem_rd, mem_wr, mem_to_reg, reg_to_acc, acc_to_reg;
  logic          assign_val, busy, done, mem_err;
  logic [CW-1:0] instr_cnt;
  logic [14:0]   outs;

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] exp_cnt;

  logic [8:0]  t_ins  [10];
  logic        t_zero [10];
  logic        t_neg  [10];
  logic [14:0] t_exp  [10];

  always #5 Clk = ~Clk;

  assign outs = {pc_inc, jump_en, sc_en, sc_clr, reg_exe, imm_exe, mem_rd, mem_wr,
                 mem_to_reg, reg_to_acc, acc_to_reg, assign_val, busy, done, mem_err};

  ctrl_seq #(.IW(9), .OPW(4), .TO_W(4), .CW(CW)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Instruction (Instruction),
    .instr_valid (instr_valid),
    .ZERO        (ZERO),
    .NEG         (NEG),
    .mem_ack     (mem_ack),
    .pc_inc      (pc_inc),
    .jump_en     (jump_en),
    .sc_en       (sc_en),
    .sc_clr      (sc_clr),
    .reg_exe     (reg_exe),
    .imm_exe     (imm_exe),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_to_reg  (mem_to_reg),
    .reg_to_acc  (reg_to_acc),
    .acc_to_reg  (acc_to_reg),
    .assign_val  (assign_val),
    .busy        (busy),
    .done        (done),
    .mem_err     (mem_err),
    .instr_cnt   (instr_cnt)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present one instruction in FETCH; returns one tick later, in EXEC.
  task automatic fetch(input logic [8:0] ins);
    Instruction = ins;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    Instruction = '0;
    #1;
  endtask

  initial begin
    t_ins[0] = 9'h0B0; t_zero[0] = 0; t_neg[0] = 0; t_exp[0] = JMP | IMM | BUSY;   // BNE imm taken
    t_ins[1] = 9'h0C0; t_zero[1] = 0; t_neg[1] = 1; t_exp[1] = PC | REG | BUSY;    // BGE reg not taken
    t_ins[2] = 9'h0C0; t_zero[2] = 1; t_neg[2] = 0; t_exp[2] = JMP | REG | BUSY;   // BGE reg taken
    t_ins[3] = 9'h180; t_zero[3] = 0; t_neg[3] = 0; t_exp[3] = JMP | BUSY;         // JMP
    t_ins[4] = 9'h130; t_zero[4] = 0; t_neg[4] = 0; t_exp[4] = PC | A2R | BUSY;    // MOV mode1
    t_ins[5] = 9'h120; t_zero[5] = 0; t_neg[5] = 0; t_exp[5] = PC | R2A | BUSY;    // MOV mode0
    t_ins[6] = 9'h140; t_zero[6] = 0; t_neg[6] = 0; t_exp[6] = PC | ASG | BUSY;    // ASSIGN
    t_ins[7] = 9'h160; t_zero[7] = 0; t_neg[7] = 0; t_exp[7] = PC | SCCL | BUSY;   // CLRSC
    t_ins[8] = 9'h020; t_zero[8] = 0; t_neg[8] = 0; t_exp[8] = PC | SCEN | REG | BUSY; // SUB reg
    t_ins[9] = 9'h1A0; t_zero[9] = 1; t_neg[9] = 1; t_exp[9] = PC | BUSY;          // undefined -> NOP
    exp_cnt = '0;

    // Reset state
    tick(); tick();
    chk("reset_outs", 32'(outs), 32'h0);
    chk("reset_cnt", 32'(instr_cnt), 32'h0);
    Reset = 1'b0;
    tick();
    chk("idle_outs", 32'(outs), 32'h0);

    // Start -> FETCH, ADD imm
    Start = 1'b1;
    tick();
    Start = 1'b0;
    #1;
    chk("fetch_busy", 32'(outs), 32'(BUSY));
    fetch(9'h013);
    chk("add_imm", 32'(outs), 32'(PC | SCEN | IMM | BUSY));
    tick(); exp_cnt++;
    chk("add_cnt", 32'(instr_cnt), 32'(exp_cnt));
    chk("add_back_fetch", 32'(outs), 32'(BUSY));

    // BEQ reg, taken then not taken
    ZERO = 1'b1;
    fetch(9'h080);
    chk("beq_taken", 32'(outs), 32'(JMP | REG | BUSY));
    tick(); exp_cnt++;
    ZERO = 1'b0;
    fetch(9'h080);
    chk("beq_not_taken", 32'(outs), 32'(PC | REG | BUSY));
    tick(); exp_cnt++;
    chk("beq_cnt", 32'(instr_cnt), 32'(exp_cnt));

    // Remaining single-cycle opcodes
    for (int i = 0; i < 10; i++) begin
      ZERO = t_zero[i];
      NEG  = t_neg[i];
      fetch(t_ins[i]);
      chk($sformatf("op_%03h_%0d", t_ins[i], i), 32'(outs), 32'(t_exp[i]));
      tick(); exp_cnt++;
      chk($sformatf("op_cnt_%0d", i), 32'(instr_cnt), 32'(exp_cnt));
    end
    ZERO = 1'b0;
    NEG  = 1'b0;

    // HALT opcode, then resume
    fetch(9'h1E0);
    chk("halt_exec", 32'(outs), 32'(BUSY));
    tick(); exp_cnt++;
    chk("halt_state", 32'(outs), 32'(DONE));
    chk("halt_cnt", 32'(instr_cnt), 32'(exp_cnt));
    Start = 1'b1;
    tick();
    Start = 1'b0;
    #1;
    chk("halt_resume", 32'(outs), 32'(BUSY));

    // LW with ack on the third MEM cycle
    fetch(9'h0E2);
    chk("lw_exec", 32'(outs), 32'(BUSY));
    tick();
    chk("lw_mem1", 32'(outs), 32'(MRD | BUSY));
    tick();
    chk("lw_mem2", 32'(outs), 32'(MRD | BUSY));
    tick();
    mem_ack = 1'b1;
    #1;
    chk("lw_mem3_ack", 32'(outs), 32'(PC | MRD | M2R | BUSY));
    tick(); exp_cnt++;
    mem_ack = 1'b0;
    #1;
    chk("lw_after", 32'(outs), 32'(BUSY));
    chk("lw_cnt", 32'(instr_cnt), 32'(exp_cnt));

    // LW with ack in the terminal (15th) MEM cycle: ack wins
    fetch(9'h0E2);
    tick();
    for (int i = 1; i < 15; i++) begin
      chk($sformatf("lw_term_wait%0d", i), 32'(outs), 32'(MRD | BUSY));
      tick();
    end
    mem_ack = 1'b1;
    #1;
    chk("lw_term_ack", 32'(outs), 32'(PC | MRD | M2R | BUSY));
    tick(); exp_cnt++;
    mem_ack = 1'b0;
    #1;
    chk("lw_term_after", 32'(outs), 32'(BUSY));

    // SW with no ack: 15 cycles of mem_wr then error halt
    fetch(9'h100);
    chk("sw_exec", 32'(outs), 32'(BUSY));
    tick();
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("sw_wait%0d", i), 32'(outs), 32'(MWR | BUSY));
      tick();
    end
    chk("sw_timeout", 32'(outs), 32'(DONE | ERR));
    chk("sw_cnt", 32'(instr_cnt), 32'(exp_cnt));
    Start = 1'b1;
    tick();
    Start = 1'b0;
    #1;
    chk("err_sticky", 32'(outs), 32'(BUSY | ERR));

    // Reset mid-access beats Start and mem_ack
    fetch(9'h0E2);
    tick();
    chk("rst_pre_mem", 32'(outs), 32'(MRD | BUSY | ERR));
    Reset   = 1'b1;
    mem_ack = 1'b1;
    Start   = 1'b1;
    #1;
    tick();
    chk("rst_mid_outs", 32'(outs), 32'h0);
    chk("rst_mid_cnt", 32'(instr_cnt), 32'h0);
    Reset   = 1'b0;
    mem_ack = 1'b0;
    Start   = 1'b0;
    exp_cnt = '0;
    tick();
    chk("rst_idle", 32'(outs), 32'h0);

    // 2^CW+1 back-to-back NOPs with stray Start pulses: counter wraps to 1
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Instruction = 9'h1A0;
    instr_valid = 1'b1;
    for (int i = 0; i < 2 * ((1 << CW) + 1); i++) begin
      Start = ((i % 7) == 3);
      tick();
    end
    Start = 1'b0;
    instr_valid = 1'b0;
    #1;
    chk("wrap_cnt", 32'(instr_cnt), 32'h1);
    chk("wrap_fetch", 32'(outs), 32'(BUSY));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
